spi_xfer_engine: RTL

SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_xfer_engine.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI transfer-engine types: FSM state encodings and SPI mode 0 constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_STORE = 3'd5
  } spi_state_e;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider and edge generator: a half-period elapses every idiv+1 enabled cycles,
// producing one-cycle rise/fall strobes when toggling is allowed.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 ien,
  input  logic                 itoggle,
  input  logic [DIV_WIDTH-1:0] idiv,
  output logic                 ohalf,
  output logic                 orise,
  output logic                 ofall,
  output logic                 osclk
);

  logic [DIV_WIDTH-1:0] cnt_q = '0;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 sclk_q = SPI_CPOL;
  logic                 sclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    ohalf  = ien && (cnt_q == idiv);
    orise  = ohalf && itoggle && !sclk_q;
    ofall  = ohalf && itoggle && sclk_q;
    if (!ien) begin
      cnt_d  = '0;
      sclk_d = SPI_CPOL;
    end else if (ohalf) begin
      cnt_d = '0;
      if (itoggle) sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_q  <= '0;
      sclk_q <= SPI_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign osclk = sclk_q;

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI mode 0 master moving words from a TX FIFO to the wire and back into an RX FIFO.
// Define SPI_XFER_LOOPBACK_EN to add the iloopback input (RX samples omosi instead of imiso).
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ienable,
  input  logic [DIV_WIDTH-1:0]  idiv,
  input  logic                  itx_valid,
  output logic                  otx_req,
  input  logic                  itx_resp,
  input  logic [DATA_WIDTH-1:0] itx_data,
  output logic                  otx_ack,
  output logic                  orx_req,
  output logic [DATA_WIDTH-1:0] orx_data,
  input  logic                  irx_ack,
  output logic                  osclk,
  output logic                  omosi,
  input  logic                  imiso,
  output logic                  ocs_n,
`ifdef SPI_XFER_LOOPBACK_EN
  input  logic                  iloopback,
`endif
  output logic                  obusy,
  output logic                  orx_stall
);

  localparam int              BCW      = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

  spi_state_e            state_q = ST_IDLE;
  spi_state_e            state_d;
  logic [DIV_WIDTH-1:0]  div_q = '0, div_d;
  logic [BCW-1:0]        bit_cnt_q = '0, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sr_q = '0, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q = '0, rx_sr_d;
  logic [DATA_WIDTH-1:0] orx_data_q = '0, orx_data_d;
  logic                  otx_req_q = 1'b0, otx_req_d;
  logic                  otx_ack_q = 1'b0, otx_ack_d;
  logic                  orx_req_q = 1'b0, orx_req_d;
  logic                  omosi_q = 1'b0, omosi_d;
  logic                  ocs_n_q = 1'b1, ocs_n_d;
  logic                  obusy_q = 1'b0, obusy_d;
  logic                  orx_stall_q = 1'b0, orx_stall_d;

  logic gen_en, gen_toggle, half, rise, fall, sample_bit;

  assign gen_en     = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign gen_toggle = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

`ifdef SPI_XFER_LOOPBACK_EN
  assign sample_bit = iloopback ? omosi_q : imiso;
`else
  assign sample_bit = imiso;
`endif

  // The captured divider, not the live idiv, paces the whole word.
  spi_sclk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sclk_gen (
    .iclk    (iclk),
    .irst    (irst),
    .ien     (gen_en),
    .itoggle (gen_toggle),
    .idiv    (div_q),
    .ohalf   (half),
    .orise   (rise),
    .ofall   (fall),
    .osclk   (osclk)
  );

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    orx_data_d  = orx_data_q;
    otx_req_d   = otx_req_q;
    otx_ack_d   = 1'b0;
    orx_req_d   = orx_req_q;
    omosi_d     = omosi_q;
    ocs_n_d     = ocs_n_q;
    orx_stall_d = orx_stall_q;
    if (rise) rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], sample_bit};
    case (state_q)
      ST_IDLE: begin
        if (ienable && itx_valid) begin
          otx_req_d = 1'b1;
          div_d     = idiv;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (itx_resp) begin
          tx_sr_d   = itx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          otx_req_d = 1'b0;
          otx_ack_d = 1'b1;
          ocs_n_d   = 1'b0;
          omosi_d   = itx_data[DATA_WIDTH-1];
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_sr_d   = tx_sr_q << 1;
            omosi_d   = tx_sr_q[DATA_WIDTH-2];
          end
        end
      end
      ST_HOLD: begin
        if (half) begin
          ocs_n_d     = 1'b1;
          omosi_d     = 1'b0;
          orx_req_d   = 1'b1;
          orx_data_d  = rx_sr_q;
          orx_stall_d = 1'b1;
          state_d     = ST_STORE;
        end
      end
      ST_STORE: begin
        if (irx_ack) begin
          orx_req_d   = 1'b0;
          orx_stall_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    obusy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      orx_data_q  <= '0;
      otx_req_q   <= 1'b0;
      otx_ack_q   <= 1'b0;
      orx_req_q   <= 1'b0;
      omosi_q     <= 1'b0;
      ocs_n_q     <= 1'b1;
      obusy_q     <= 1'b0;
      orx_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      orx_data_q  <= orx_data_d;
      otx_req_q   <= otx_req_d;
      otx_ack_q   <= otx_ack_d;
      orx_req_q   <= orx_req_d;
      omosi_q     <= omosi_d;
      ocs_n_q     <= ocs_n_d;
      obusy_q     <= obusy_d;
      orx_stall_q <= orx_stall_d;
    end
  end

  assign otx_req   = otx_req_q;
  assign otx_ack   = otx_ack_q;
  assign orx_req   = orx_req_q;
  assign orx_data  = orx_data_q;
  assign omosi     = omosi_q;
  assign ocs_n     = ocs_n_q;
  assign obusy     = obusy_q;
  assign orx_stall = orx_stall_q;

endmodule
